pc_stall_div: RTL

PC_STALL_DIV -- requirements
Module: pc_stall_div

---
 rtl/pc_stall_div.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pc_stall_div.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) that holds the PC while it works.
// Latency DATA_WIDTH+1 cycles (1 for divide-by-zero or signed overflow); no backpressure, start is a held level.
module pc_stall_div #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy,
    output logic                  done,
    output logic                  stall_n
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W:0]     rem_q;
    logic [W-1:0]   quo_q;
    logic [W-1:0]   dvs_q;
    logic           qsign_q;
    logic           rsign_q;
    logic           sel_rem_q;
    logic [W-1:0]   result_q;

    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic           div_zero;
    logic           ovf;
    logic [W-1:0]   special_res;

    logic [W+1:0]   shifted;
    logic [W+1:0]   diff;
    logic           step_ok;
    logic [W:0]     rem_n;
    logic [W-1:0]   quo_n;
    logic [W-1:0]   q_fin;
    logic [W-1:0]   r_fin;

    // Unsigned ops never carry a sign, so their magnitudes are the raw operands.
    assign a_neg = ~op[0] & rs1[W-1];
    assign b_neg = ~op[0] & rs2[W-1];
    assign a_mag = a_neg ? -rs1 : rs1;
    assign b_mag = b_neg ? -rs2 : rs2;

    assign div_zero = (rs2 == '0);
    assign ovf      = ~op[0] & (rs1 == {1'b1, {(W-1){1'b0}}}) & (rs2 == '1);

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = op[1] ? rs1 : '1;
        end else begin
            special_res = op[1] ? '0 : rs1;
        end
    end

    // One restoring step; the top bit of diff is the borrow that decides restore.
    assign shifted = {rem_q, quo_q[W-1]};
    assign diff    = shifted - {2'b00, dvs_q};
    assign step_ok = ~diff[W+1];
    assign rem_n   = step_ok ? diff[W:0] : shifted[W:0];
    assign quo_n   = {quo_q[W-2:0], step_ok};

    assign q_fin = qsign_q ? -quo_n : quo_n;
    assign r_fin = rsign_q ? -rem_n[W-1:0] : rem_n[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            sel_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sel_rem_q <= op[1];
                        qsign_q   <= a_neg ^ b_neg;
                        rsign_q   <= a_neg;
                        dvs_q     <= b_mag;
                        quo_q     <= a_mag;
                        rem_q     <= '0;
                        if (div_zero || ovf) begin
                            result_q <= special_res;
                            state_q  <= DONE;
                        end else begin
                            cnt_q   <= CW'(W);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q <= sel_rem_q ? r_fin : q_fin;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign result  = result_q;
    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign stall_n = ~(((state_q == IDLE) & start) | (state_q == CALC));

endmodule
